perceptron_driver: RTL and testbench

//   Initiator for the perceptron en/in/ready/out/acc interface. Plays a fixed

---
 rtl/perceptron_driver_if.sv | 22 ++
 rtl/perceptron_driver.sv | 171 +++++++++++++++++
 tb/tb_perceptron_driver.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_driver_if.sv
// Perceptron en/in/ready/out/acc link.
// master drives en/in_o; slave returns ready_i/out_i/acc_i.
interface perceptron_driver_if #(
  parameter int WIDTH = 25,
  parameter int ACC_W = $clog2(WIDTH)
);
  logic             en;
  logic [WIDTH-1:0] in_o;
  logic             ready_i;
  logic [1:0]       out_i;
  logic [ACC_W-1:0] acc_i;

  modport master (
    output en, in_o,
    input  ready_i, out_i, acc_i
  );

  modport slave (
    input  en, in_o,
    output ready_i, out_i, acc_i
  );
endinterface

// File: rtl/perceptron_driver.sv
// Self-test initiator: plays a fixed pattern sequence into a perceptron.
// Ports: clk, rst_n, start, bus (master), busy, done, pass/fail counts,
//   timeout (sticky), last_out/last_acc (latest captured result).
module perceptron_driver #(
  parameter int               WIDTH     = 25,
  parameter int               ACC_W     = $clog2(WIDTH),
  parameter int               NUM_TESTS = 4,
  parameter logic [15:0]      SEQ       = 16'b0110,
  parameter logic [WIDTH-1:0] PAT0      = {1'b0, 24'h454544},
  parameter logic [WIDTH-1:0] PAT1      = {1'b1, 24'h151151},
  parameter logic [1:0]       EXP_OUT0  = 2'd2,
  parameter logic [ACC_W-1:0] EXP_ACC0  = 4,
  parameter logic [1:0]       EXP_OUT1  = 2'd3,
  parameter logic [ACC_W-1:0] EXP_ACC1  = 11,
  parameter int               MIN_HOLD  = 6,
  parameter int               GAP_CYC   = 2,
  parameter int               TIMEOUT   = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  perceptron_driver_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [4:0]         pass_cnt,
  output logic [4:0]         fail_cnt,
  output logic               timeout,
  output logic [1:0]         last_out,
  output logic [ACC_W-1:0]   last_acc
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  logic [2:0]       r_state;
  logic             r_en;
  logic [WIDTH-1:0] r_in;
  logic             r_busy;
  logic             r_done;
  logic [4:0]       r_pass;
  logic [4:0]       r_fail;
  logic             r_tmo;
  logic [1:0]       r_last_out;
  logic [ACC_W-1:0] r_last_acc;
  logic [3:0]       r_slot;
  logic [HW-1:0]    r_hold;
  logic [WW-1:0]    r_wait;
  logic [GW-1:0]    r_gap;

  logic [3:0]       w_load_slot;
  logic [WIDTH-1:0] w_pat;
  logic [1:0]       w_exp_out;
  logic [ACC_W-1:0] w_exp_acc;
  logic             w_hold_ok;
  logic             w_last;
  logic             w_match;

  // Next pattern is chosen on the way into LOAD so en and in_o rise
  // together and en stays low for exactly GAP_CYC cycles.
  assign w_load_slot = (r_state == S_GAP) ? r_slot + 4'd1 : 4'd0;
  assign w_pat       = SEQ[w_load_slot] ? PAT1 : PAT0;
  assign w_exp_out   = SEQ[r_slot] ? EXP_OUT1 : EXP_OUT0;
  assign w_exp_acc   = SEQ[r_slot] ? EXP_ACC1 : EXP_ACC0;
  // hold_cnt is 0 in the first WAIT cycle; this cycle counts as held.
  assign w_hold_ok   = r_hold >= HW'(MIN_HOLD - 1);
  assign w_last      = r_slot == 4'(NUM_TESTS - 1);
  assign w_match     = (bus.out_i == w_exp_out) &&
                       (bus.acc_i == w_exp_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_in       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_tmo      <= 1'b0;
      r_last_out <= '0;
      r_last_acc <= '0;
      r_slot     <= '0;
      r_hold     <= '0;
      r_wait     <= '0;
      r_gap      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= '0;
            r_fail  <= '0;
            r_tmo   <= 1'b0;
            r_slot  <= '0;
            r_en    <= 1'b1;
            r_in    <= w_pat;
          end
        end
        S_LOAD: begin
          r_hold  <= '0;
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ready_i && w_hold_ok) begin
            r_state <= S_CAP;
          end else if (r_wait == WW'(TIMEOUT - 1)) begin
            r_fail  <= r_fail + 5'd1;
            r_tmo   <= 1'b1;
            r_en    <= 1'b0;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else begin
            r_wait <= r_wait + 1'b1;
            if (r_hold < HW'(MIN_HOLD))
              r_hold <= r_hold + 1'b1;
          end
        end
        S_CAP: begin
          r_last_out <= bus.out_i;
          r_last_acc <= bus.acc_i;
          if (w_match)
            r_pass <= r_pass + 5'd1;
          else
            r_fail <= r_fail + 5'd1;
          r_en    <= 1'b0;
          r_gap   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_CYC - 1)) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_slot  <= w_load_slot;
              r_en    <= 1'b1;
              r_in    <= w_pat;
              r_state <= S_LOAD;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.en   = r_en;
  assign bus.in_o = r_in;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign timeout  = r_tmo;
  assign last_out = r_last_out;
  assign last_acc = r_last_acc;

endmodule

// File: tb/tb_perceptron_driver.sv
// Bench for perceptron_driver with a behavioural perceptron model.
// Directed steps; each comparison is an immediate assertion.
module tb_perceptron_driver;

  localparam logic [24:0] PC = {1'b0, 24'h454544};
  localparam logic [24:0] PX = {1'b1, 24'h151151};

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] pass_cnt;
  logic [4:0] fail_cnt;
  logic       timeout;
  logic [1:0] last_out;
  logic [4:0] last_acc;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  logic [4:0] m_cnt;

  logic [24:0] pats[$];
  int          hi[$];
  int          lo[$];

  perceptron_driver_if #(.WIDTH(25)) bus ();

  perceptron_driver #(.TIMEOUT(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .timeout  (timeout),
    .last_out (last_out),
    .last_acc (last_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Perceptron model: ready 10 cycles after en rises.
  // mode 0 normal, 1 wrong class for cross, 2 ready tied 1, 3 tied 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      m_cnt <= '0;
    else if (!bus.en)
      m_cnt <= '0;
    else if (m_cnt != 5'd31)
      m_cnt <= m_cnt + 5'd1;
  end

  always_comb begin
    bus.ready_i = 1'b0;
    bus.out_i   = 2'd2;
    bus.acc_i   = 5'd4;
    if (mode == 2)
      bus.ready_i = 1'b1;
    else if (mode != 3)
      bus.ready_i = bus.en && (m_cnt >= 5'd10);
    if (bus.in_o[24]) begin
      bus.out_i = (mode == 1) ? 2'd1 : 2'd3;
      bus.acc_i = 5'd11;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples once per cycle until done, logging pattern per en rise
  // and the lengths of en-high and en-low runs.
  task automatic run_wait(input string tag, input int budget);
    bit pen;
    bit fell;
    bit ok;
    int hc;
    int lc;
    pen  = 0;
    fell = 0;
    ok   = 0;
    hc   = 0;
    lc   = 0;
    pats.delete();
    hi.delete();
    lo.delete();
    for (int i = 0; i < budget; i++) begin
      if (bus.en) begin
        if (!pen) begin
          pats.push_back(bus.in_o);
          if (fell) lo.push_back(lc);
          hc = 0;
        end
        hc++;
      end else begin
        if (pen) begin
          hi.push_back(hc);
          fell = 1;
          lc = 0;
        end
        lc++;
      end
      pen = bus.en;
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_reach_done"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_in", 32'(bus.in_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    chk("rst_last", 32'({last_out, last_acc}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Normal run: C,X,X,C all correct.
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    run_wait("t1", 200);
    chk("t1_npat", 32'(pats.size()), 32'd4);
    chk("t1_pat0", 32'(pats[0]), 32'(PC));
    chk("t1_pat1", 32'(pats[1]), 32'(PX));
    chk("t1_pat2", 32'(pats[2]), 32'(PX));
    chk("t1_pat3", 32'(pats[3]), 32'(PC));
    chk("t1_hi0", 32'(hi[0]), 32'd12);
    chk("t1_lo0", 32'(lo[0]), 32'd2);
    chk("t1_pass", 32'(pass_cnt), 32'd4);
    chk("t1_fail", 32'(fail_cnt), 32'd0);
    chk("t1_tmo", 32'(timeout), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_last", 32'({last_out, last_acc}), 32'({2'd2, 5'd4}));

    // ready tied high: LOAD + MIN_HOLD WAIT + CAPTURE with en high.
    mode = 2;
    pulse_start();
    run_wait("t3", 200);
    chk("t3_hi0", 32'(hi[0]), 32'd8);
    chk("t3_hi3", 32'(hi[3]), 32'd8);
    chk("t3_pass", 32'(pass_cnt), 32'd4);

    // ready tied low: every slot times out after 20 WAIT cycles.
    mode = 3;
    pulse_start();
    run_wait("t4", 400);
    chk("t4_hi0", 32'(hi[0]), 32'd21);
    chk("t4_lo0", 32'(lo[0]), 32'd2);
    chk("t4_lo2", 32'(lo[2]), 32'd2);
    chk("t4_pass", 32'(pass_cnt), 32'd0);
    chk("t4_fail", 32'(fail_cnt), 32'd4);
    chk("t4_tmo", 32'(timeout), 32'd1);

    // start from DONE clears; a start during WAIT is ignored.
    mode = 0;
    pulse_start();
    chk("t6_fail_clr", 32'(fail_cnt), 32'd0);
    chk("t6_tmo_clr", 32'(timeout), 32'd0);
    chk("t6_done_clr", 32'(done), 32'd0);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_cycles", 32'(n), 32'd56);
    chk("t6_pass", 32'(pass_cnt), 32'd4);
    chk("t6_fail", 32'(fail_cnt), 32'd0);

    // Wrong class for cross: two fails, final circle slot captured.
    mode = 1;
    pulse_start();
    run_wait("t2", 200);
    chk("t2_pass", 32'(pass_cnt), 32'd2);
    chk("t2_fail", 32'(fail_cnt), 32'd2);
    chk("t2_last_out", 32'(last_out), 32'd2);
    chk("t2_last_acc", 32'(last_acc), 32'd4);

    // Async reset during slot 2 WAIT, then replay from slot 0.
    mode = 0;
    pulse_start();
    repeat (32) @(negedge clk);
    chk("t5_pre_en", 32'(bus.en), 32'd1);
    chk("t5_pre_pat", 32'(bus.in_o), 32'(PX));
    chk("t5_pre_pass", 32'(pass_cnt), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_en", 32'(bus.en), 32'd0);
    chk("t5_pass", 32'(pass_cnt), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_idle", 32'(bus.en), 32'd0);
    pulse_start();
    run_wait("t5", 200);
    chk("t5_pat0", 32'(pats[0]), 32'(PC));
    chk("t5_npat", 32'(pats.size()), 32'd4);
    chk("t5_pass_end", 32'(pass_cnt), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
